rx_fifo_read_ctrl: RTL

//  Read-domain sequencer for the I2C RX async FIFO. Prefetches one byte from the FIFO into a

---
 rtl/rx_fifo_read_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rx_fifo_read_ctrl.sv
// RX FIFO read-side sequencer: byte prefetch, host reads,
// flush drain, idle timeout and data interrupt.
module rx_fifo_read_ctrl #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned TIMEOUT  = 32,
  parameter int unsigned TO_W     = 6
) (
  input  logic                rclk_i,
  input  logic                rrst_ni,
  input  logic                en_i,
  input  logic                flush_i,
  input  logic                rd_req_i,
  input  logic [DATASIZE-1:0] fifo_rdata_i,
  input  logic                fifo_rempty_i,
  input  logic                fifo_ralmost_i,
  output logic                fifo_rinc_o,
  output logic [DATASIZE-1:0] rd_data_o,
  output logic                rd_ack_o,
  output logic                rd_err_o,
  output logic                hold_valid_o,
  output logic                rx_timeout_o,
  output logic                flush_done_o,
  output logic                irq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                load;
  logic                flush_entry;
  logic                hold_valid_q;
  logic [DATASIZE-1:0] hold_data_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [TO_W-1:0]     to_cnt_d;
  logic                to_hit;
  logic                to_clr;

  assign hold_valid_o = hold_valid_q;

  // State register
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state, pop strobe and flush completion
  always_comb begin
    state_d      = state_q;
    fifo_rinc_o  = 1'b0;
    flush_done_o = 1'b0;
    load         = 1'b0;
    flush_entry  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d     = S_FLUSH;
          flush_entry = 1'b1;
        end else if (en_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d     = S_FLUSH;
          flush_entry = 1'b1;
        end else if (!en_i) begin
          state_d = S_IDLE;
        end else begin
          load = !fifo_rempty_i &
                 (!hold_valid_q | rd_req_i);
          fifo_rinc_o = load;
        end
      end
      S_FLUSH: begin
        fifo_rinc_o = !fifo_rempty_i;
        if (fifo_rempty_i) begin
          flush_done_o = 1'b1;
          state_d = en_i ? S_RUN : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: load on pop, drop on read or flush
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else if (flush_entry) begin
      hold_valid_q <= 1'b0;
    end else if (load) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= fifo_rdata_i;
    end else if (rd_req_i) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Read return: old byte goes out while a new one loads
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      rd_ack_o  <= 1'b0;
      rd_err_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o <= rd_req_i;
      rd_err_o <= rd_req_i & ~hold_valid_q;
      if (rd_req_i)
        rd_data_o <= hold_valid_q ? hold_data_q : '0;
    end
  end

  // Age of the unread held byte, saturating
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (!hold_valid_q || rd_req_i)
      to_cnt_d = '0;
    else if (to_cnt_q != '1)
      to_cnt_d = to_cnt_q + TO_W'(1);
  end

  assign to_hit = (to_cnt_d == TO_W'(TIMEOUT - 1));
  assign to_clr = rd_req_i | flush_i | ~en_i;

  // Timeout counter and sticky flag
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      to_cnt_q     <= '0;
      rx_timeout_o <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (to_clr)      rx_timeout_o <= 1'b0;
      else if (to_hit) rx_timeout_o <= 1'b1;
    end
  end

  // Registered data interrupt
  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) irq_o <= 1'b0;
    else irq_o <= en_i & hold_valid_q &
                  (~fifo_ralmost_i | rx_timeout_o);
  end

endmodule
